// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse: conditioning stage for the timer's pause/start key.
// The raw push-button goes through a two-flop synchroniser and a counter-based
// debounce FSM. Outputs are a registered press pulse, a release pulse, the
// debounced level and a run/pause toggle.
// Optional feature macro: AUTO_REPEAT_EN. When it is defined, a held key
// produces repeat press pulses after REPEAT_DELAY cycles and then every
// REPEAT_PERIOD cycles. When it is undefined, no repeat counter exists.
module key_debounce_pulse #(
   parameter int DEBOUNCE_CYCLES = 240000,
   parameter bit KEY_ACTIVE_LOW  = 1'b1,
   parameter int REPEAT_DELAY    = 6000000,
   parameter int REPEAT_PERIOD   = 1200000
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic key_in,
   output logic key_pulse,
   output logic release_pulse,
   output logic key_level,
   output logic key_toggle
);

   // Counter width covers the longest interval any counter has to measure.
   localparam int MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int CNT_MAX = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

   // Raw pin level of a released key (the pull-up level for active-low keys).
   localparam logic RELEASED_RAW = KEY_ACTIVE_LOW;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_WAIT_PRESS   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_WAIT_RELEASE = 2'd3
   } state_t;

   logic          r_sync1;
   logic          r_sync2;
   logic          w_key_s;
   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_key_pulse;
   logic          r_release_pulse;
   logic          r_key_level;
   logic          r_key_toggle;

`ifdef AUTO_REPEAT_EN
   localparam logic [CW-1:0] RPT_DELAY_LAST  = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] RPT_PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

   logic [CW-1:0] r_rpt_cnt;
   logic          r_rpt_first;
   logic          w_rpt_fire;
`endif

   // Two-flop synchroniser. These are the only flops that look at key_in.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_sync1 <= RELEASED_RAW;
         r_sync2 <= RELEASED_RAW;
      end else begin
         r_sync1 <= key_in;
         r_sync2 <= r_sync1;
      end
   end

   // Normalise the synchronised key so that 1 always means pressed.
   assign w_key_s = r_sync2 ^ RELEASED_RAW;

`ifdef AUTO_REPEAT_EN
   // Repeat is due when the first delay or the running period has elapsed.
   always_comb begin
      w_rpt_fire = 1'b0;
      if (r_rpt_first) begin
         w_rpt_fire = (r_rpt_cnt == RPT_DELAY_LAST);
      end else begin
         w_rpt_fire = (r_rpt_cnt == RPT_PERIOD_LAST);
      end
   end
`endif

   // Debounce FSM with registered pulse, level and toggle outputs.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state         <= ST_IDLE;
         r_cnt           <= CNT_ZERO;
         r_key_pulse     <= 1'b0;
         r_release_pulse <= 1'b0;
         r_key_level     <= 1'b0;
         r_key_toggle    <= 1'b0;
`ifdef AUTO_REPEAT_EN
         r_rpt_cnt       <= CNT_ZERO;
         r_rpt_first     <= 1'b1;
`endif
      end else begin
         r_key_pulse     <= 1'b0;
         r_release_pulse <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_key_level <= 1'b0;
               if (w_key_s) begin
                  r_state <= ST_WAIT_PRESS;
                  r_cnt   <= CNT_ZERO;
               end
            end
            ST_WAIT_PRESS: begin
               if (!w_key_s) begin
                  // Bounce: drop back without any output.
                  r_state <= ST_IDLE;
                  r_cnt   <= CNT_ZERO;
               end else if (r_cnt == DB_LAST) begin
                  r_state      <= ST_PRESSED;
                  r_cnt        <= CNT_ZERO;
                  r_key_pulse  <= 1'b1;
                  r_key_level  <= 1'b1;
                  r_key_toggle <= ~r_key_toggle;
`ifdef AUTO_REPEAT_EN
                  r_rpt_cnt    <= CNT_ZERO;
                  r_rpt_first  <= 1'b1;
`endif
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            ST_PRESSED: begin
               if (!w_key_s) begin
                  r_state <= ST_WAIT_RELEASE;
                  r_cnt   <= CNT_ZERO;
               end else begin
                  r_cnt <= CNT_ZERO;
`ifdef AUTO_REPEAT_EN
                  // A release bounce freezes this schedule instead of restarting it.
                  if (w_rpt_fire) begin
                     r_key_pulse <= 1'b1;
                     r_rpt_cnt   <= CNT_ZERO;
                     r_rpt_first <= 1'b0;
                  end else begin
                     r_rpt_cnt <= r_rpt_cnt + CNT_ONE;
                  end
`endif
               end
            end
            ST_WAIT_RELEASE: begin
               if (w_key_s) begin
                  // Release bounce: key is still considered pressed.
                  r_state <= ST_PRESSED;
                  r_cnt   <= CNT_ZERO;
               end else if (r_cnt == DB_LAST) begin
                  r_state         <= ST_IDLE;
                  r_cnt           <= CNT_ZERO;
                  r_release_pulse <= 1'b1;
                  r_key_level     <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_cnt       <= CNT_ZERO;
               r_key_level <= 1'b0;
            end
         endcase
      end
   end

   assign key_pulse     = r_key_pulse;
   assign release_pulse = r_release_pulse;
   assign key_level     = r_key_level;
   assign key_toggle    = r_key_toggle;

endmodule
